// File: rtl/circular_op_sequencer_if.sv
// Command and step handshake bundle for the circular arc sequencer.
// The slave side is the sequencer; the master side is the command source plus step consumer.
interface circular_op_sequencer_if #(
   parameter int NUM_BITS = 8
);
   localparam int STEP_BITS = NUM_BITS + 3;

   logic                        cmd_valid;
   logic                        cmd_ready;
   logic                        is_cw;
   logic signed [NUM_BITS-1:0]  start_x;
   logic signed [NUM_BITS-1:0]  start_y;
   logic signed [NUM_BITS-1:0]  end_x;
   logic signed [NUM_BITS-1:0]  end_y;
   logic signed [NUM_BITS-1:0]  r;
   logic                        precise_crossing_axes;
   logic                        is_full_circle;
   logic                        step_valid;
   logic                        step_ready;
   logic signed [1:0]           step_dx;
   logic signed [1:0]           step_dy;
   logic                        busy;
   logic                        done;
   logic [STEP_BITS-1:0]        num_steps;

   modport master (
      output cmd_valid, is_cw, start_x, start_y, end_x, end_y, r,
             precise_crossing_axes, is_full_circle, step_ready,
      input  cmd_ready, step_valid, step_dx, step_dy, busy, done, num_steps
   );

   modport slave (
      input  cmd_valid, is_cw, start_x, start_y, end_x, end_y, r,
             precise_crossing_axes, is_full_circle, step_ready,
      output cmd_ready, step_valid, step_dx, step_dy, busy, done, num_steps
   );
endinterface

// File: rtl/circular_op_sequencer.sv
// Circular (G02/G03) arc sequencer: latches one arc command, sizes it with the step-count
// calculator, then emits unit X/Y steps over a valid/ready handshake until the count runs out.

module CircularOpHandler_NumStepsCalculator #(
   parameter int NUM_BITS = 8
) (
   input  logic signed [NUM_BITS-1:0]  i_start_x,
   input  logic signed [NUM_BITS-1:0]  i_start_y,
   input  logic signed [NUM_BITS-1:0]  i_end_x,
   input  logic signed [NUM_BITS-1:0]  i_end_y,
   input  logic signed [NUM_BITS-1:0]  i_r,
   input  logic                        i_is_cw,
   input  logic                        i_precise_crossing_axes,
   input  logic                        i_is_full_circle,
   output logic [NUM_BITS+2:0]         o_num_steps
);
   localparam int STEP_BITS = NUM_BITS + 3;
   localparam int T_BITS    = NUM_BITS + 4;

   // Maps a point to its Manhattan distance travelled CCW from (r,0); one lap is 8r.
   // Without precise axis crossing the point snaps back to the start of its quadrant.
   function automatic logic signed [T_BITS-1:0] arcParam(
      input logic signed [NUM_BITS-1:0] x,
      input logic signed [NUM_BITS-1:0] y,
      input logic signed [T_BITS-1:0]   rad,
      input logic                       precise
   );
      logic signed [T_BITS-1:0] xe, ye, base, offs;
      logic                     xPos, xNeg, yPos, yNeg;
      xe   = {{(T_BITS-NUM_BITS){x[NUM_BITS-1]}}, x};
      ye   = {{(T_BITS-NUM_BITS){y[NUM_BITS-1]}}, y};
      xNeg = x[NUM_BITS-1];
      yNeg = y[NUM_BITS-1];
      xPos = !xNeg && (x != '0);
      yPos = !yNeg && (y != '0);
      if (xPos && !yNeg) begin
         base = '0;
         offs = (rad - xe) + ye;
      end else if (!xPos && yPos) begin
         base = rad <<< 1;
         offs = (rad - ye) - xe;
      end else if (xNeg && !yPos) begin
         base = rad <<< 2;
         offs = (rad + xe) - ye;
      end else begin
         base = (rad <<< 2) + (rad <<< 1);
         offs = (rad + ye) + xe;
      end
      return precise ? (base + offs) : base;
   endfunction

   logic signed [T_BITS-1:0] w_rad;
   logic signed [T_BITS-1:0] w_tStart;
   logic signed [T_BITS-1:0] w_tEnd;
   logic signed [T_BITS-1:0] w_diff;

   assign w_rad    = {{(T_BITS-NUM_BITS){i_r[NUM_BITS-1]}}, i_r};
   assign w_tStart = arcParam(i_start_x, i_start_y, w_rad, i_precise_crossing_axes);
   assign w_tEnd   = arcParam(i_end_x, i_end_y, w_rad, i_precise_crossing_axes);

   // Distance along the lap in the direction of travel, wrapped into [0, 8r); a full circle
   // with coincident endpoints is a whole lap rather than nothing.
   always_comb begin
      w_diff = i_is_cw ? (w_tStart - w_tEnd) : (w_tEnd - w_tStart);
      if (w_diff[T_BITS-1]) begin
         w_diff = w_diff + (w_rad <<< 3);
      end
      if ((w_diff == '0) && i_is_full_circle) begin
         w_diff = w_rad <<< 3;
      end
      o_num_steps = w_diff[STEP_BITS-1:0];
   end
endmodule

module circular_op_sequencer #(
   parameter int NUM_BITS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   circular_op_sequencer_if.slave   bus
);
   localparam int STEP_BITS = NUM_BITS + 3;
   localparam int SQ_BITS   = 2 * NUM_BITS + 2;

   typedef enum logic [1:0] {IDLE, CALC, STEP, DONE} state_t;

   state_t                      r_state;
   logic                        r_cmdReady;
   logic                        r_busy;
   logic                        r_stepValid;
   logic                        r_done;
   logic                        r_isCw;
   logic                        r_precise;
   logic                        r_fullCircle;
   logic signed [NUM_BITS-1:0]  r_startX;
   logic signed [NUM_BITS-1:0]  r_startY;
   logic signed [NUM_BITS-1:0]  r_endX;
   logic signed [NUM_BITS-1:0]  r_endY;
   logic signed [NUM_BITS-1:0]  r_radius;
   logic signed [NUM_BITS-1:0]  r_posX;
   logic signed [NUM_BITS-1:0]  r_posY;
   logic [STEP_BITS-1:0]        r_numSteps;
   logic [STEP_BITS-1:0]        r_remaining;

   logic [STEP_BITS-1:0]        w_calcSteps;
   logic signed [1:0]           w_sgnX;
   logic signed [1:0]           w_sgnY;
   logic signed [1:0]           w_moveX;
   logic signed [1:0]           w_moveY;
   logic signed [SQ_BITS-1:0]   w_posXs;
   logic signed [SQ_BITS-1:0]   w_posYs;
   logic signed [SQ_BITS-1:0]   w_radS;
   logic signed [SQ_BITS-1:0]   w_nextX;
   logic signed [SQ_BITS-1:0]   w_nextY;
   logic signed [SQ_BITS-1:0]   w_errX;
   logic signed [SQ_BITS-1:0]   w_errY;
   logic signed [SQ_BITS-1:0]   w_absErrX;
   logic signed [SQ_BITS-1:0]   w_absErrY;
   logic                        w_takeX;
   logic signed [1:0]           w_stepDx;
   logic signed [1:0]           w_stepDy;

   CircularOpHandler_NumStepsCalculator #(
      .NUM_BITS (NUM_BITS)
   ) u_calc (
      .i_start_x               (r_startX),
      .i_start_y               (r_startY),
      .i_end_x                 (r_endX),
      .i_end_y                 (r_endY),
      .i_r                     (r_radius),
      .i_is_cw                 (r_isCw),
      .i_precise_crossing_axes (r_precise),
      .i_is_full_circle        (r_fullCircle),
      .o_num_steps             (w_calcSteps)
   );

   // The tangent at the current point gives one candidate move per axis; an axis whose
   // sign term is zero offers no move, otherwise the move landing nearer the circle wins.
   always_comb begin
      w_sgnX    = (r_posX == '0) ? 2'sb00 : (r_posX[NUM_BITS-1] ? 2'sb11 : 2'sb01);
      w_sgnY    = (r_posY == '0) ? 2'sb00 : (r_posY[NUM_BITS-1] ? 2'sb11 : 2'sb01);
      w_moveX   = r_isCw ? w_sgnY : -w_sgnY;
      w_moveY   = r_isCw ? -w_sgnX : w_sgnX;
      w_posXs   = {{(SQ_BITS-NUM_BITS){r_posX[NUM_BITS-1]}}, r_posX};
      w_posYs   = {{(SQ_BITS-NUM_BITS){r_posY[NUM_BITS-1]}}, r_posY};
      w_radS    = {{(SQ_BITS-NUM_BITS){r_radius[NUM_BITS-1]}}, r_radius};
      w_nextX   = w_posXs + {{(SQ_BITS-2){w_moveX[1]}}, w_moveX};
      w_nextY   = w_posYs + {{(SQ_BITS-2){w_moveY[1]}}, w_moveY};
      w_errX    = (w_nextX * w_nextX) + (w_posYs * w_posYs) - (w_radS * w_radS);
      w_errY    = (w_posXs * w_posXs) + (w_nextY * w_nextY) - (w_radS * w_radS);
      w_absErrX = w_errX[SQ_BITS-1] ? -w_errX : w_errX;
      w_absErrY = w_errY[SQ_BITS-1] ? -w_errY : w_errY;
      w_takeX   = (w_moveX != 2'sb00) && ((w_moveY == 2'sb00) || (w_absErrX <= w_absErrY));
      w_stepDx  = 2'sb00;
      w_stepDy  = 2'sb00;
      if (r_stepValid) begin
         if (w_takeX) begin
            w_stepDx = w_moveX;
         end else begin
            w_stepDy = w_moveY;
         end
      end
   end

   assign bus.cmd_ready  = r_cmdReady;
   assign bus.busy       = r_busy;
   assign bus.step_valid = r_stepValid;
   assign bus.done       = r_done;
   assign bus.num_steps  = r_numSteps;
   assign bus.step_dx    = w_stepDx;
   assign bus.step_dy    = w_stepDy;

   // Control FSM; handshake flags are registered alongside the state so they change only
   // on state transitions, and reset has priority over any pending step.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cmdReady   <= 1'b1;
         r_busy       <= 1'b0;
         r_stepValid  <= 1'b0;
         r_done       <= 1'b0;
         r_isCw       <= 1'b0;
         r_precise    <= 1'b0;
         r_fullCircle <= 1'b0;
         r_startX     <= '0;
         r_startY     <= '0;
         r_endX       <= '0;
         r_endY       <= '0;
         r_radius     <= '0;
         r_posX       <= '0;
         r_posY       <= '0;
         r_numSteps   <= '0;
         r_remaining  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.cmd_valid && r_cmdReady) begin
                  r_isCw       <= bus.is_cw;
                  r_precise    <= bus.precise_crossing_axes;
                  r_fullCircle <= bus.is_full_circle;
                  r_startX     <= bus.start_x;
                  r_startY     <= bus.start_y;
                  r_endX       <= bus.end_x;
                  r_endY       <= bus.end_y;
                  r_radius     <= bus.r;
                  r_posX       <= bus.start_x;
                  r_posY       <= bus.start_y;
                  r_cmdReady   <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= CALC;
               end
            end
            CALC: begin
               r_numSteps  <= w_calcSteps;
               r_remaining <= w_calcSteps;
               if (w_calcSteps == '0) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_stepValid <= 1'b1;
                  r_state     <= STEP;
               end
            end
            STEP: begin
               if (r_stepValid && bus.step_ready) begin
                  r_posX      <= r_posX + {{(NUM_BITS-2){w_stepDx[1]}}, w_stepDx};
                  r_posY      <= r_posY + {{(NUM_BITS-2){w_stepDy[1]}}, w_stepDy};
                  r_remaining <= r_remaining - STEP_BITS'(1);
                  if (r_remaining == STEP_BITS'(1)) begin
                     r_stepValid <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            DONE: begin
               r_done     <= 1'b0;
               r_busy     <= 1'b0;
               r_cmdReady <= 1'b1;
               r_state    <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_circular_op_sequencer.sv
// Directed bench for circular_op_sequencer: quarter arcs, full circle, zero length,
// backpressure and mid-arc reset, all against hand-worked expected values.
module tb_circular_op_sequencer;
   logic clk;
   logic reset;
   int   checkCount;
   int   errorCount;

   int   arcSteps;
   int   arcX;
   int   arcY;
   int   firstDx;
   int   firstDy;
   int   maxErr;
   int   badAxis;
   int   doneGap;
   int   stallChanged;

   circular_op_sequencer_if #(.NUM_BITS(8)) busIf ();

   circular_op_sequencer #(.NUM_BITS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busIf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   // Outputs that must sit at their reset values while idle after a reset.
   task automatic checkResetState(input string tag);
      checkOutput({tag, ".cmd_ready"}, int'(busIf.cmd_ready), 1);
      checkOutput({tag, ".busy"}, int'(busIf.busy), 0);
      checkOutput({tag, ".step_valid"}, int'(busIf.step_valid), 0);
      checkOutput({tag, ".step_dx"}, int'(busIf.step_dx), 0);
      checkOutput({tag, ".step_dy"}, int'(busIf.step_dy), 0);
      checkOutput({tag, ".done"}, int'(busIf.done), 0);
      checkOutput({tag, ".num_steps"}, int'(busIf.num_steps), 0);
   endtask

   // Presents one command for a single cycle; returns in the cycle after acceptance.
   task automatic applyStimulus(input bit cw, input int sx, input int sy, input int ex,
                                input int ey, input int rad, input bit full);
      busIf.is_cw                 = cw;
      busIf.start_x               = 8'(sx);
      busIf.start_y               = 8'(sy);
      busIf.end_x                 = 8'(ex);
      busIf.end_y                 = 8'(ey);
      busIf.r                     = 8'(rad);
      busIf.precise_crossing_axes = 1'b1;
      busIf.is_full_circle        = full;
      busIf.cmd_valid             = 1'b1;
      waitCycle();
      busIf.cmd_valid             = 1'b0;
   endtask

   // Consumes steps, tracking position from the offered deltas; optionally stalls step
   // index stallAt for stallLen cycles, or returns early once abortAfter steps are taken.
   task automatic runArc(input int sx, input int sy, input int rad, input int stallAt,
                         input int stallLen, input int abortAfter);
      int  lastAccept;
      int  stallCnt;
      int  savedDx;
      int  savedDy;
      int  dx;
      int  dy;
      int  err;
      bit  gotFirst;
      arcSteps     = 0;
      arcX         = sx;
      arcY         = sy;
      firstDx      = 99;
      firstDy      = 99;
      maxErr       = 0;
      badAxis      = 0;
      doneGap      = -1;
      stallChanged = 0;
      lastAccept   = -100;
      stallCnt     = 0;
      savedDx      = 0;
      savedDy      = 0;
      gotFirst     = 1'b0;
      busIf.step_ready = 1'b1;
      for (int s = 0; s < 200; s++) begin
         if (busIf.done) begin
            doneGap = s - lastAccept;
            break;
         end
         if (arcSteps == stallAt && stallCnt > 0) begin
            if (busIf.step_valid !== 1'b1 || int'(busIf.step_dx) != savedDx ||
                int'(busIf.step_dy) != savedDy) begin
               stallChanged++;
            end
         end
         if (abortAfter >= 0 && arcSteps == abortAfter) begin
            break;
         end
         if (busIf.step_valid) begin
            dx = int'(busIf.step_dx);
            dy = int'(busIf.step_dy);
            if (!gotFirst) begin
               firstDx  = dx;
               firstDy  = dy;
               gotFirst = 1'b1;
            end
            if ((dx != 0) == (dy != 0)) badAxis++;
            if (arcSteps == stallAt && stallCnt < stallLen) begin
               if (stallCnt == 0) begin
                  savedDx = dx;
                  savedDy = dy;
               end
               stallCnt++;
               busIf.step_ready = 1'b0;
            end else begin
               busIf.step_ready = 1'b1;
               arcX += dx;
               arcY += dy;
               arcSteps++;
               lastAccept = s;
               err = arcX * arcX + arcY * arcY - rad * rad;
               if (err < 0) err = -err;
               if (err > maxErr) maxErr = err;
            end
         end
         waitCycle();
      end
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      reset = 1'b1;
      busIf.cmd_valid = 1'b0;
      busIf.is_cw = 1'b0;
      busIf.start_x = '0;
      busIf.start_y = '0;
      busIf.end_x = '0;
      busIf.end_y = '0;
      busIf.r = '0;
      busIf.precise_crossing_axes = 1'b0;
      busIf.is_full_circle = 1'b0;
      busIf.step_ready = 1'b1;
      waitCycle();
      waitCycle();
      checkResetState("reset");
      reset = 1'b0;
      waitCycle();

      // CCW quarter r=4 from (4,0) to (0,4)
      applyStimulus(1'b0, 4, 0, 0, 4, 4, 1'b0);
      checkOutput("ccw.calcReady", int'(busIf.cmd_ready), 0);
      checkOutput("ccw.calcBusy", int'(busIf.busy), 1);
      checkOutput("ccw.calcValid", int'(busIf.step_valid), 0);
      runArc(4, 0, 4, -1, 0, -1);
      checkOutput("ccw.numSteps", int'(busIf.num_steps), 8);
      checkOutput("ccw.steps", arcSteps, 8);
      checkOutput("ccw.firstDx", firstDx, 0);
      checkOutput("ccw.firstDy", firstDy, 1);
      checkOutput("ccw.endX", arcX, 0);
      checkOutput("ccw.endY", arcY, 4);
      checkOutput("ccw.doneGap", doneGap, 1);
      checkOutput("ccw.badAxis", badAxis, 0);
      waitCycle();
      checkOutput("ccw.readyAfter", int'(busIf.cmd_ready), 1);
      checkOutput("ccw.donePulse", int'(busIf.done), 0);
      checkOutput("ccw.idleBusy", int'(busIf.busy), 0);

      // CW between the same endpoints goes three quarters the long way round
      applyStimulus(1'b1, 4, 0, 0, 4, 4, 1'b0);
      runArc(4, 0, 4, -1, 0, -1);
      checkOutput("cw.numSteps", int'(busIf.num_steps), 24);
      checkOutput("cw.steps", arcSteps, 24);
      checkOutput("cw.firstDx", firstDx, 0);
      checkOutput("cw.firstDy", firstDy, -1);
      checkOutput("cw.endX", arcX, 0);
      checkOutput("cw.endY", arcY, 4);
      checkOutput("cw.badAxis", badAxis, 0);
      checkOutput("cw.doneGap", doneGap, 1);
      waitCycle();

      // Full circle r=2 back to (2,0)
      applyStimulus(1'b0, 2, 0, 2, 0, 2, 1'b1);
      runArc(2, 0, 2, -1, 0, -1);
      checkOutput("full.numSteps", int'(busIf.num_steps), 16);
      checkOutput("full.steps", arcSteps, 16);
      checkOutput("full.endX", arcX, 2);
      checkOutput("full.endY", arcY, 0);
      checkOutput("full.errWithin3", int'(maxErr <= 3), 1);
      waitCycle();

      // Zero-length command: done at N+2, ready again at N+3, no steps at all
      applyStimulus(1'b0, 3, 0, 3, 0, 3, 1'b0);
      checkOutput("zero.n1Valid", int'(busIf.step_valid), 0);
      checkOutput("zero.n1Done", int'(busIf.done), 0);
      waitCycle();
      checkOutput("zero.n2Done", int'(busIf.done), 1);
      checkOutput("zero.n2Valid", int'(busIf.step_valid), 0);
      checkOutput("zero.n2Ready", int'(busIf.cmd_ready), 0);
      checkOutput("zero.numSteps", int'(busIf.num_steps), 0);
      waitCycle();
      checkOutput("zero.n3Ready", int'(busIf.cmd_ready), 1);
      checkOutput("zero.n3Done", int'(busIf.done), 0);
      checkOutput("zero.n3Valid", int'(busIf.step_valid), 0);

      // Backpressure: hold the second step for three cycles
      applyStimulus(1'b0, 4, 0, 0, 4, 4, 1'b0);
      runArc(4, 0, 4, 1, 3, -1);
      checkOutput("bp.stable", stallChanged, 0);
      checkOutput("bp.steps", arcSteps, 8);
      checkOutput("bp.numSteps", int'(busIf.num_steps), 8);
      checkOutput("bp.endX", arcX, 0);
      checkOutput("bp.endY", arcY, 4);
      checkOutput("bp.doneGap", doneGap, 1);
      waitCycle();

      // Reset after the third CW step, then a normal CCW arc
      applyStimulus(1'b1, 4, 0, 0, 4, 4, 1'b0);
      runArc(4, 0, 4, -1, 0, 3);
      checkOutput("rst.stepsBefore", arcSteps, 3);
      checkOutput("rst.posX", arcX, 3);
      checkOutput("rst.posY", arcY, -2);
      checkOutput("rst.validBefore", int'(busIf.step_valid), 1);
      reset = 1'b1;
      waitCycle();
      checkResetState("rst");
      reset = 1'b0;
      waitCycle();
      checkOutput("rst.noDone", int'(busIf.done), 0);
      checkOutput("rst.idleReady", int'(busIf.cmd_ready), 1);
      applyStimulus(1'b0, 4, 0, 0, 4, 4, 1'b0);
      runArc(4, 0, 4, -1, 0, -1);
      checkOutput("rst.againSteps", arcSteps, 8);
      checkOutput("rst.againNum", int'(busIf.num_steps), 8);
      checkOutput("rst.againX", arcX, 0);
      checkOutput("rst.againY", arcY, 4);
      checkOutput("rst.againDone", doneGap, 1);
      waitCycle();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end
endmodule

// File: doc/circular_op_sequencer.md
# circular_op_sequencer

Sequencer for circular (G02/G03-style) motion commands. It accepts one arc command, registers it, and obtains the total step count from the `CircularOpHandler_NumStepsCalculator` datapath it instantiates. It then walks the arc one unit step at a time toward the motor/step consumer over a valid/ready handshake. It sits between the command decoder and the step output stage of the processor.

## Interface
- `NUM_BITS`, default `BYTE_BITS`: signed width of coordinates and radius.
- `STEP_BITS`, localparam, `NUM_BITS+3`: step-count width.
- `SQ_BITS`, localparam, `2*NUM_BITS+2`: signed width of the radius-error arithmetic.

Ports:
- `clk` input, 1: single clock.
- `reset` input, 1: already decided; synchronous, active-high.
- `cmd_valid` input, 1: command present.
- `cmd_ready` output, 1: block can accept a command (IDLE only).
- `is_cw` input, 1: clockwise when 1.
- `start_x`, `start_y`, `end_x`, `end_y` input, `NUM_BITS`: signed, relative to arc centre.
- `r` input, `NUM_BITS`: radius, positive.
- `precise_crossing_axes` input, 1: forwarded to the calculator.
- `is_full_circle` input, 1: forwarded to the calculator.
- `step_valid` output, 1: a step is offered.
- `step_ready` input, 1: consumer accepts the step.
- `step_dx`, `step_dy` output, 2: signed unit step in {-1,0,+1}. Exactly one is non-zero when `step_valid`=1.
- `busy` output, 1: high in every state except IDLE.
- `done` output, 1: one-cycle pulse after the last step is accepted, or after a zero-step command.
- `num_steps` output, `STEP_BITS`: latched total of the current/last command.

## Operation
- **States:** IDLE, CALC, STEP, DONE.
- **IDLE:** `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`, latch all command fields into registers. Load `pos_x`/`pos_y` with start_x/start_y. Go to CALC.
- **CALC:** the calculator inputs are driven only from the latched registers.
  - Register its output into `num_steps` and the `remaining` counter.
  - Go to DONE if the count is 0, else to STEP.
- **STEP:** `step_valid`=1. Direction is taken from the tangent at (`pos_x`,`pos_y`).
  - CCW: x moves by -sgn(pos_y), y moves by +sgn(pos_x).
  - CW: x moves by +sgn(pos_y), y moves by -sgn(pos_x).
  - sgn(0)=0. An axis whose sign term is 0 is not a candidate.
- **Step choice:**
  - With two candidates, compute e = x'^2+y'^2-r^2 in `SQ_BITS` signed for each. Pick the smaller |e|.
  - A tie picks the x move.
  - With one candidate, take it.
- **Handshake (`step_valid`&`step_ready`):**
  - Update `pos_x`/`pos_y` by the step and decrement `remaining`.
  - If `remaining` was 1, go to DONE; else stay in STEP.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **Arithmetic:** positions are `NUM_BITS` signed and never exceed |r|. Squares and the error term are sign-extended to `SQ_BITS` before the multiply, so there is no overflow.
- The end point is not compared; termination is by count only.

## Timing
- **Reset values:** state IDLE, `cmd_ready`=1, `busy`=0, `step_valid`=0, `step_dx`=`step_dy`=0, `done`=0, `num_steps`=0, `remaining`=0, positions 0.
- **Latency:** a command accepted in cycle N gives CALC in N+1 and first `step_valid` in N+2. With zero steps, `done` is high in N+2.
- **Throughput:** one step per cycle when `step_ready` is held high. `step_valid` stays high back-to-back.
- **Backpressure:** while `step_valid`=1 and `step_ready`=0, `step_dx`/`step_dy`/`pos` are stable. `step_valid` never drops before acceptance.
- **Outputs:** `step_dx`/`step_dy` are a combinational function of registered state only, never of `step_ready`. They are 0 whenever `step_valid`=0.
- The last step is accepted in cycle M, then `done`=1 in M+1 and `cmd_ready`=1 in M+2.
- `cmd_valid` outside IDLE is ignored; there is no queueing.
- **Reset mid-operation:** `reset` in any state returns to IDLE next cycle with reset values. The pending step is dropped and no `done` is generated.
- `num_steps` holds its value until the next CALC.

## Test plan
- **CCW quarter, r=4, (4,0)->(0,4):**
  - `num_steps`=8 and first step (0,+1).
  - Eight steps end at (0,4).
  - `done` pulses 1 cycle after the 8th accept; `step_ready` held 1 throughout.
- **CW same endpoints:**
  - `num_steps`=24 and first step (0,-1).
  - Final pos (0,4).
  - No step has both components non-zero.
- **Full circle, r=2, start=end=(2,0), `is_full_circle`=1, CCW:**
  - 16 steps returning to (2,0).
  - Every intermediate |x^2+y^2-4| ≤ 3.
- **Zero length, start=end=(3,0), `is_full_circle`=0:**
  - `step_valid` never asserts.
  - `done` in N+2 and `cmd_ready` in N+3.
- **Backpressure:** hold `step_ready`=0 for 3 cycles on step 2 of the r=4 CCW arc.
  - `step_valid`/`dx`/`dy` are unchanged over those cycles.
  - The total step count is still 8.
- **Reset after step 3 of the CW arc:**
  - Next cycle: IDLE, all outputs at reset values, no `done`.
  - A following command then runs normally.
